i2c_bit_engine: RTL

//   Bit-level I2C PHY below i2c_master: executes one byte-level command (START, WRITE, READ, STOP)
//   and drives open-drain SCL/SDA with prescaled timing. Samples slave ACK / read data and returns
//   one response per command. i2c_master sequences commands; pads map *_oe=1 to drive-low.

---
 rtl/i2c_bit_engine_pkg.sv | 38 +++
 rtl/i2c_bit_engine_prescaler.sv | 30 +++
 rtl/i2c_bit_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bit_engine_pkg.sv
// Shared opcode, FSM state and bit-phase encodings for the I2C bit engine and its sequencer.
package i2c_bit_engine_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_e;

  function automatic state_e first_state(input op_e op);
    state_e st;
    case (op)
      OP_START:         st = ST_START;
      OP_WRITE, OP_READ: st = ST_DATA;
      OP_STOP:          st = ST_STOP;
      default:          st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/i2c_bit_engine_prescaler.sv
// Quarter-bit tick generator: one tick every CLK_DIV clocks, restarted from zero by clear or stall.
module i2c_bit_engine_prescaler #(
  parameter int CLK_DIV = 250,
  parameter int CNT_W   = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic tick
);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;

  assign wrap_s = (cnt_r == CNT_W'(CLK_DIV - 1));
  assign tick   = wrap_s && !clear && !stall;

  // Divider counter; a stall parks it at zero so counting resumes with a full period
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear || stall || wrap_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C PHY: runs one START/WRITE/READ/STOP command on open-drain SCL/SDA, one response each.
// Optional build macro I2C_CLOCK_STRETCH_EN honours slave clock stretching while SCL is released.
module i2c_bit_engine
  import i2c_bit_engine_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int CNT_W   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_e      state_r;
  phase_e      phase_r;
  op_e         op_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  tx_r;
  logic [7:0]  rx_r;
  logic        ack_r;
  logic        nack_r;
  logic [1:0]  scl_sync_r;
  logic [1:0]  sda_sync_r;
  logic        scl_oe_r;
  logic        sda_oe_r;
  logic        cmd_ready_r;
  logic        rsp_valid_r;
  logic [7:0]  rsp_data_r;
  logic        rsp_nack_r;
  logic        accept_s;
  logic        stall_s;
  logic        tick_s;

  assign accept_s  = cmd_valid && cmd_ready_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = ~cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_nack  = rsp_nack_r;
  assign scl_oe    = scl_oe_r;
  assign sda_oe    = sda_oe_r;

`ifdef I2C_CLOCK_STRETCH_EN
  // Waiting for the p2 tick means SCL was released at p1; hold everything while the bus still reads low
  assign stall_s = (state_r != ST_IDLE) && (state_r != ST_DONE) &&
                   (phase_r == PH_2) && !scl_sync_r[1];
`else
  logic stretch_unused_s;
  assign stretch_unused_s = scl_sync_r[1];
  assign stall_s          = 1'b0;
`endif

  i2c_bit_engine_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept_s),
    .stall   (stall_s),
    .tick    (tick_s)
  );

  // Two-flop synchronizers for the asynchronous pad levels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
    end
  end

  // Command FSM: each tick executes the action of phase_r and advances to the next phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_0;
      op_r        <= OP_START;
      bit_cnt_r   <= 3'd7;
      tx_r        <= 8'h00;
      rx_r        <= 8'h00;
      ack_r       <= 1'b1;
      nack_r      <= 1'b0;
      scl_oe_r    <= 1'b0;
      sda_oe_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_nack_r  <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (tick_s) begin
        phase_r <= phase_e'(phase_r + 2'd1);
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            op_r        <= op_e'(cmd_op);
            tx_r        <= cmd_data;
            ack_r       <= cmd_ack_out;
            nack_r      <= 1'b0;
            bit_cnt_r   <= 3'd7;
            phase_r     <= PH_0;
            state_r     <= first_state(op_e'(cmd_op));
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            case (phase_r)
              PH_0:    sda_oe_r <= 1'b0;
              PH_1:    scl_oe_r <= 1'b0;
              PH_2:    sda_oe_r <= 1'b1;
              PH_3: begin
                scl_oe_r <= 1'b1;
                state_r  <= ST_DONE;
              end
              default: state_r <= ST_DONE;
            endcase
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: begin
                scl_oe_r <= 1'b1;
                sda_oe_r <= (op_r == OP_WRITE) ? ~tx_r[bit_cnt_r] : 1'b0;
              end
              PH_1:    scl_oe_r <= 1'b0;
              PH_2: begin
                if (op_r == OP_READ) begin
                  rx_r <= {rx_r[6:0], sda_sync_r[1]};
                end
              end
              PH_3: begin
                scl_oe_r <= 1'b1;
                if (bit_cnt_r == 3'd0) begin
                  state_r <= ST_ACK;
                end else begin
                  bit_cnt_r <= bit_cnt_r - 3'd1;
                end
              end
              default: state_r <= ST_ACK;
            endcase
          end
        end
        ST_ACK: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: begin
                scl_oe_r <= 1'b1;
                sda_oe_r <= (op_r == OP_READ) ? ~ack_r : 1'b0;
              end
              PH_1:    scl_oe_r <= 1'b0;
              PH_2: begin
                if (op_r == OP_WRITE) begin
                  nack_r <= sda_sync_r[1];
                end
              end
              PH_3: begin
                scl_oe_r <= 1'b1;
                state_r  <= ST_DONE;
              end
              default: state_r <= ST_DONE;
            endcase
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            case (phase_r)
              PH_0:    sda_oe_r <= 1'b1;
              PH_1:    scl_oe_r <= 1'b0;
              PH_2:    sda_oe_r <= 1'b0;
              PH_3:    state_r  <= ST_DONE;
              default: state_r  <= ST_DONE;
            endcase
          end
        end
        ST_DONE: begin
          rsp_valid_r <= 1'b1;
          rsp_nack_r  <= (op_r == OP_WRITE) ? nack_r : 1'b0;
          if (op_r == OP_READ) begin
            rsp_data_r <= rx_r;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
